// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame scheduler: top-state encoding and
// default counter width.
package fft_ctrl_pkg;

  // Top-level session state. The encoding is fixed so that status
  // consumers can decode it directly.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Default width of the frame_limit / frames_done counters.
  localparam int DEFAULT_CNT_W = 16;

endpackage : fft_ctrl_pkg

// File: rtl/fft_stage_tracker.sv
// Tracks one FFT stage: registers its start strobe, keeps a busy flag
// between start and done, and flags done pulses that arrive while the
// stage is idle.
module fft_stage_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic start_req,    // start condition, already qualified by the caller
  input  logic done,         // completion pulse from the stage
  output logic start,        // registered one-cycle start strobe
  output logic busy,         // stage is working on a frame
  output logic done_ok,      // done accepted (stage was busy)
  output logic protocol_err  // sticky: done seen while idle
);

  // A done only counts when the stage actually owns a frame.
  assign done_ok = done && busy;

  // Start strobe, busy flag and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start        <= 1'b0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      // NOTE: every register here reads the pre-edge value of busy; the
      // non-blocking assignments keep that true regardless of statement order.
      start <= start_req;
      if (start_req) begin
        busy <= 1'b1;
      end else if (done_ok) begin
        busy <= 1'b0;
      end
      if (done && !busy) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule : fft_stage_tracker

// File: rtl/fft_frame_scheduler.sv
// Frame scheduler for the three-stage FFT pipeline (input clocking,
// butterfly calculation, output clocking). Issues stage start strobes from
// registered state so that consecutive frames overlap, tracks the two
// inter-stage buffers, limits the number of frames per session and supports
// a graceful stop (enable low) or flush.
module fft_frame_scheduler
  import fft_ctrl_pkg::*;
#(
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter int FFT_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flush,
  input  logic [CNT_W-1:0] frame_limit,
  output logic             load_start,
  input  logic             load_done,
  output logic             calc_start,
  input  logic             calc_done,
  output logic             out_start,
  input  logic             out_done,
  output logic             busy,
  output logic             session_done,
  output logic [CNT_W-1:0] frames_done,
  output logic             protocol_err
);

  // FFT_SIZE only describes the attached datapath; reject nonsense sizes.
  if (FFT_SIZE < 2) begin : g_fft_size_check
    $error("fft_frame_scheduler: FFT_SIZE must be at least 2");
  end

  state_t           state;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] loads_issued;
  logic             buf_a_full;   // input buffer holds a frame awaiting calc
  logic             buf_b_full;   // result buffer holds a frame awaiting output

  logic load_busy, calc_busy, out_busy;
  logic load_ok, calc_ok, out_ok;
  logic load_err, calc_err, out_err;
  logic load_req, calc_req, out_req;
  logic limit_reached;
  logic pipe_empty;

  // A zero limit means "run until told to stop".
  assign limit_reached = (limit_q != '0) && (loads_issued == limit_q);

  // Start conditions, all taken from registered state. Loads are also
  // gated by the live enable/flush levels so that no frame is issued on
  // the same edge a stop request is seen.
  assign load_req = (state == RUN) && enable && !flush && !load_busy &&
                    !buf_a_full && !limit_reached;
  assign calc_req = !calc_busy && buf_a_full && !buf_b_full;
  assign out_req  = !out_busy && buf_b_full;

  assign pipe_empty = !load_busy && !calc_busy && !out_busy &&
                      !buf_a_full && !buf_b_full;

  assign protocol_err = load_err || calc_err || out_err;

  fft_stage_tracker u_load_trk (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_req    (load_req),
    .done         (load_done),
    .start        (load_start),
    .busy         (load_busy),
    .done_ok      (load_ok),
    .protocol_err (load_err)
  );

  fft_stage_tracker u_calc_trk (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_req    (calc_req),
    .done         (calc_done),
    .start        (calc_start),
    .busy         (calc_busy),
    .done_ok      (calc_ok),
    .protocol_err (calc_err)
  );

  fft_stage_tracker u_out_trk (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_req    (out_req),
    .done         (out_done),
    .start        (out_start),
    .busy         (out_busy),
    .done_ok      (out_ok),
    .protocol_err (out_err)
  );

  // Inter-stage buffer occupancy. A buffer is filled by the producing
  // stage's done and emptied when the consuming stage is started; the two
  // events can never coincide because the producer only starts on an
  // empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_a_full <= 1'b0;
      buf_b_full <= 1'b0;
    end else begin
      if (calc_req) begin
        buf_a_full <= 1'b0;
      end else if (load_ok) begin
        buf_a_full <= 1'b1;
      end
      if (out_req) begin
        buf_b_full <= 1'b0;
      end else if (calc_ok) begin
        buf_b_full <= 1'b1;
      end
    end
  end

  // Session FSM with registered busy/session_done plus the load and
  // delivered-frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      session_done <= 1'b0;
      limit_q      <= '0;
      loads_issued <= '0;
      frames_done  <= '0;
    end else begin
      session_done <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && !flush) begin
            state        <= RUN;
            busy         <= 1'b1;
            limit_q      <= frame_limit;
            loads_issued <= '0;
            frames_done  <= '0;
          end
        end
        RUN: begin
          if (!enable || flush || limit_reached) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state        <= IDLE;
            busy         <= 1'b0;
            session_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Loads only issue in RUN and frames only complete while a stage is
      // busy, so neither update collides with the IDLE->RUN clear above.
      if (load_req && (loads_issued != '1)) begin
        loads_issued <= loads_issued + 1'b1;
      end
      if (out_ok && (frames_done != '1)) begin
        frames_done <= frames_done + 1'b1;
      end
    end
  end

endmodule : fft_frame_scheduler

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler. Three behavioural stage models
// answer each start strobe with a done pulse after a programmable number
// of cycles; a monitor counts strobes and tracks buffer occupancy
// independently of the design.
module tb_fft_frame_scheduler;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             flush;
  logic [CNT_W-1:0] frame_limit;
  logic             load_start, calc_start, out_start;
  logic             load_done, calc_done_m, calc_spur, out_done;
  logic             calc_done;
  logic             busy, session_done, protocol_err;
  logic [CNT_W-1:0] frames_done;

  assign calc_done = calc_done_m | calc_spur;

  fft_frame_scheduler #(.CNT_W(CNT_W), .FFT_SIZE(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .frame_limit  (frame_limit),
    .load_start   (load_start),
    .load_done    (load_done),
    .calc_start   (calc_start),
    .calc_done    (calc_done),
    .out_start    (out_start),
    .out_done     (out_done),
    .busy         (busy),
    .session_done (session_done),
    .frames_done  (frames_done),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int load_lat = 8;
  int calc_lat = 20;
  int out_lat  = 8;
  logic abort_models = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state
  int   cyc    = 0;
  int   n_load = 0, n_calc = 0, n_out = 0, n_sess = 0, n_viol = 0;
  int   load_cycs[$];
  int   calc_cycs[$];
  logic tb_bufa = 1'b0, tb_bufb = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe counting and an independent model of the two buffers.
  always @(negedge clk) begin
    if (!rst_n) begin
      tb_bufa <= 1'b0;
      tb_bufb <= 1'b0;
    end else begin
      if (load_start) begin
        n_load <= n_load + 1;
        load_cycs.push_back(cyc);
        if (tb_bufa) n_viol <= n_viol + 1;
      end
      if (calc_start) begin
        n_calc <= n_calc + 1;
        calc_cycs.push_back(cyc);
        if (!tb_bufa || tb_bufb) n_viol <= n_viol + 1;
        tb_bufa <= 1'b0;
      end
      if (out_start) begin
        n_out <= n_out + 1;
        if (!tb_bufb) n_viol <= n_viol + 1;
        tb_bufb <= 1'b0;
      end
      if (load_done) tb_bufa <= 1'b1;
      if (calc_done_m) begin
        if (tb_bufb) n_viol <= n_viol + 1;
        tb_bufb <= 1'b1;
      end
      if (session_done) n_sess <= n_sess + 1;
    end
  end

  // Stage models: done is sampled exactly <lat> edges after the start edge.
  initial begin
    load_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (load_start && !abort_models) begin
        for (int i = 1; i < load_lat && !abort_models; i++) begin @(posedge clk); #1; end
        if (!abort_models) begin
          load_done = 1'b1; @(posedge clk); #1; load_done = 1'b0;
        end
      end
    end
  end

  initial begin
    calc_done_m = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (calc_start && !abort_models) begin
        for (int i = 1; i < calc_lat && !abort_models; i++) begin @(posedge clk); #1; end
        if (!abort_models) begin
          calc_done_m = 1'b1; @(posedge clk); #1; calc_done_m = 1'b0;
        end
      end
    end
  end

  initial begin
    out_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (out_start && !abort_models) begin
        for (int i = 1; i < out_lat && !abort_models; i++) begin @(posedge clk); #1; end
        if (!abort_models) begin
          out_done = 1'b1; @(posedge clk); #1; out_done = 1'b0;
        end
      end
    end
  end

  task automatic wait_session(input string tag, input int budget);
    int s0 = n_sess;
    int i  = 0;
    while (n_sess == s0 && i < budget) begin @(negedge clk); i++; end
    check(tag, (n_sess != s0), 1);
  endtask

  task automatic wait_loads(input string tag, input int target, input int budget);
    int i = 0;
    while (n_load < target && i < budget) begin @(negedge clk); i++; end
    check(tag, (n_load >= target), 1);
  endtask

  task automatic wait_calc(input string tag, input int target, input int budget);
    int i = 0;
    while (n_calc < target && i < budget) begin @(negedge clk); i++; end
    check(tag, (n_calc >= target), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int l0, c0, o0, s0, dl, dout;

    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; frame_limit = '0; calc_spur = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_load_start", load_start, 0);
    check("rst_busy", busy, 0);
    check("rst_frames_done", frames_done, 0);
    check("rst_protocol_err", protocol_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- Single frame, limit 1 ----
    l0 = n_load; c0 = n_calc; o0 = n_out; s0 = n_sess;
    frame_limit = 16'd1; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t1_load_start_e0", load_start, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_load_start_e1", load_start, 1);
    enable = 1'b0;
    wait_session("t1_session_timeout", 200);
    repeat (5) @(negedge clk);
    check("t1_loads", n_load - l0, 1);
    check("t1_calcs", n_calc - c0, 1);
    check("t1_outs", n_out - o0, 1);
    check("t1_sessions", n_sess - s0, 1);
    check("t1_frames_done", frames_done, 1);
    check("t1_busy_after", busy, 0);

    // ---- Overlap, limit 4 ----
    l0 = n_load; c0 = n_calc; o0 = n_out;
    frame_limit = 16'd4; enable = 1'b1;
    wait_loads("t2_loads_timeout", l0 + 4, 600);
    enable = 1'b0;
    wait_session("t2_session_timeout", 600);
    check("t2_load2_after_calc1", load_cycs[l0 + 1] - calc_cycs[c0], 1);
    check("t2_loads", n_load - l0, 4);
    check("t2_outs", n_out - o0, 4);
    check("t2_frames_done", frames_done, 4);
    check("t2_protocol_err", protocol_err, 0);

    // ---- Backpressure, unlimited, slow output ----
    out_lat = 50;
    l0 = n_load; o0 = n_out;
    frame_limit = '0; enable = 1'b1;
    repeat (400) @(negedge clk);
    dl = n_load - l0; dout = n_out - o0;
    check("t3_inflight_le3", (dl - dout <= 3), 1);
    check("t3_loads_stalled", (dl < 13), 1);
    enable = 1'b0;
    wait_session("t3_session_timeout", 1500);
    check("t3_frames_eq_loads", frames_done, n_load - l0);
    check("t3_buffer_violations", n_viol, 0);
    out_lat = 8;

    // ---- Flush with frame 3 in flight ----
    l0 = n_load;
    frame_limit = '0; enable = 1'b1;
    wait_loads("t4_loads_timeout", l0 + 3, 400);
    flush = 1'b1;
    wait_session("t4_session_timeout", 600);
    check("t4_loads", n_load - l0, 3);
    check("t4_frames_done", frames_done, 3);
    enable = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy_after", busy, 0);

    // ---- Spurious calc_done while idle ----
    o0 = n_out;
    calc_spur = 1'b1;
    @(negedge clk);
    calc_spur = 1'b0;
    check("t5_protocol_err", protocol_err, 1);
    repeat (10) @(negedge clk);
    check("t5_protocol_err_sticky", protocol_err, 1);
    check("t5_no_out_start", n_out - o0, 0);
    check("t5_busy", busy, 0);

    // ---- Asynchronous reset during calc ----
    c0 = n_calc;
    frame_limit = 16'd1; enable = 1'b1;
    wait_calc("t6_calc_timeout", c0 + 1, 100);
    repeat (5) @(negedge clk);
    abort_models = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_calc_start", calc_start, 0);
    check("t6_rst_load_start", load_start, 0);
    check("t6_rst_frames_done", frames_done, 0);
    check("t6_rst_protocol_err", protocol_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    abort_models = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_load_start_e1", load_start, 0);
    @(negedge clk);
    check("t6_load_start_e2", load_start, 1);
    enable = 1'b0;
    wait_session("t6_session_timeout", 200);
    check("t6_frames_done", frames_done, 1);
    check("t6_protocol_err", protocol_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fft_frame_scheduler
